param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter DW, default 16, data/register width; SHALL satisfy DW > AW.
REQ-002 Parameter AW, default 8, address width; the opcode field width is OW = DW-AW.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 loadPC, muxPC, loadMAR, muxMAR, loadIR, loadMDR, loadACC  in  1 each  register load enables and source selects.
REQ-006 accSel  in  2  ACC source: 0 ALU, 1 MDR, 2 quotient, 3 remainder.
REQ-007 opALU  in  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not ACC, 6 shl ACC by 1, 7 pass MDR.
REQ-008 divStart  in  1  one-cycle divide request.
REQ-009 MemQ  in  DW  memory read data.
REQ-010 MemAddr  out  AW  equals MAR.
REQ-011 MemD  out  DW  equals ACC.
REQ-012 opcode  out  OW  equals IR[OW-1:0].
REQ-013 ACC_reg, MDR_reg  out  DW  current ACC and MDR contents.
REQ-014 zflag  out  1  combinational: 1 when ACC == 0.
REQ-015 cflag  out  1  registered carry/borrow flag.
REQ-016 divBusy  out  1  divider iterating; divDone  out  1  one-cycle completion pulse; divByZero  out  1  last divide had a zero divisor.

Function
REQ-017 Every register SHALL hold its value when its load enable is low.
REQ-018 PC (AW bits) SHALL load IR[DW-1:OW] when muxPC=1 and PC+1 (mod 2^AW, wraps) when muxPC=0.
REQ-019 MAR SHALL load IR[DW-1:OW] when muxMAR=1 and PC when muxMAR=0.
REQ-020 IR SHALL load MDR, and MDR SHALL load MemQ.
REQ-021 ACC SHALL load the source chosen by accSel; when loadACC=0, ACC holds.
REQ-022 ALU results SHALL be truncated to DW bits.
REQ-023 cflag SHALL update only when loadACC=1 and accSel=0, taking these values: add = carry out; sub = borrow (1 iff ACC < MDR unsigned); shl = old ACC[DW-1]; all other ops = 0.
REQ-024 All register reads within a cycle SHALL see pre-edge values; for example, loadIR with loadMDR loads the old MDR.
REQ-025 Divider states are IDLE, RUN and DONE.
REQ-026 On divStart in IDLE or DONE, the divider SHALL latch dividend = ACC and divisor = MDR (pre-edge values) and go to RUN.
REQ-027 In RUN, the divider SHALL perform one unsigned restoring-division step per cycle for exactly DW cycles, then go to DONE.
REQ-028 divBusy SHALL be 1 exactly in RUN.
REQ-029 divDone SHALL be 1 for the first cycle in DONE, giving latency DW+1 cycles from divStart to divDone; the state then returns to IDLE.
REQ-030 Quotient and remainder registers SHALL update only on entry to DONE and SHALL otherwise hold their values.
REQ-031 accSel=2 or 3 during RUN SHALL return the previous result.
REQ-032 divStart during RUN SHALL be ignored.
REQ-033 A divisor of 0 SHALL skip RUN: DONE next cycle, quotient = all ones, remainder = dividend, divByZero = 1.
REQ-034 divByZero SHALL be cleared by the next accepted divStart that has a nonzero divisor.
REQ-035 divStart together with loadACC in the same cycle SHALL latch the old ACC as dividend.

Reset
REQ-036 When rst=0 at a clock edge: PC, MAR, IR, MDR, ACC, quotient and remainder SHALL be 0; cflag = 0; divByZero = 0; divider state IDLE; divBusy = 0; divDone = 0.
REQ-037 Reset SHALL override all load enables and divStart in the same cycle.
REQ-038 Reset mid-RUN SHALL abort the division with no divDone pulse.
REQ-039 Outputs after reset SHALL be: zflag = 1, MemAddr = 0, MemD = 0, opcode = 0.

Verification (DW=16, AW=8)
REQ-040 Fetch: PC = 0x05, MemQ = 0x2A03.
  - Cycle 1: loadMAR (muxMAR=0) -> MemAddr = 0x05.
  - Cycle 2: loadMDR -> MDR = 0x2A03.
  - Cycle 3: loadIR -> opcode = 0x03.
  - Cycle 4: loadPC (muxPC=1) -> PC = 0x2A.
REQ-041 PC wrap: PC = 0xFF, loadPC with muxPC=0 -> PC = 0x00.
REQ-042 ALU flags:
  - ACC = 0xFFFF, MDR = 0x0001, add -> ACC = 0x0000, cflag = 1, zflag = 1.
  - Then sub with MDR = 0x0001 -> ACC = 0xFFFF, cflag = 1.
REQ-043 Divide: ACC = 100, MDR = 7, divStart -> divBusy high 16 cycles, divDone at cycle 17; then accSel=2 -> ACC = 14, accSel=3 -> ACC = 2, divByZero = 0.
REQ-044 Divide by zero: ACC = 0x1234, MDR = 0, divStart -> divDone next cycle, quotient = 0xFFFF, remainder = 0x1234, divByZero = 1.
REQ-045 Abort: divStart, rst=0 at RUN cycle 8 -> divBusy = 0, no divDone pulse, accSel=2 load gives ACC = 0; a second divStart during RUN is ignored, with divDone exactly once.

Source files
------------

// File: rtl/param_datapath_if.sv
// Bus bundle for param_datapath: load enables, source selects, divide
// request and memory read data in one direction; memory address/data,
// register views, flags and divider status in the other.
//   master : drives controls and MemQ (sequencer / testbench side)
//   slave  : the datapath itself
interface param_datapath_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  localparam int unsigned OW = DW - AW;

  logic          loadPC;
  logic          muxPC;
  logic          loadMAR;
  logic          muxMAR;
  logic          loadIR;
  logic          loadMDR;
  logic          loadACC;
  logic [1:0]    accSel;
  logic [2:0]    opALU;
  logic          divStart;
  logic [DW-1:0] MemQ;

  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemD;
  logic [OW-1:0] opcode;
  logic [DW-1:0] ACC_reg;
  logic [DW-1:0] MDR_reg;
  logic          zflag;
  logic          cflag;
  logic          divBusy;
  logic          divDone;
  logic          divByZero;

  modport master (
    output loadPC, muxPC, loadMAR, muxMAR, loadIR, loadMDR, loadACC,
           accSel, opALU, divStart, MemQ,
    input  MemAddr, MemD, opcode, ACC_reg, MDR_reg, zflag, cflag,
           divBusy, divDone, divByZero
  );

  modport slave (
    input  loadPC, muxPC, loadMAR, muxMAR, loadIR, loadMDR, loadACC,
           accSel, opALU, divStart, MemQ,
    output MemAddr, MemD, opcode, ACC_reg, MDR_reg, zflag, cflag,
           divBusy, divDone, divByZero
  );
endinterface

// File: rtl/param_datapath.sv
// Accumulator datapath: PC, MAR, IR, MDR, ACC with an 8-op ALU, carry
// flag and a multi-cycle unsigned restoring divider (quotient/remainder
// selectable into ACC).
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : param_datapath_if.slave (controls, MemQ in; MemAddr, MemD,
//          opcode, ACC/MDR views, flags, divider status out)
module param_datapath #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input logic             clk,
  input logic             rst,
  param_datapath_if.slave bus
);
  localparam int unsigned OW = DW - AW;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_mar;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_mdr;
  logic [DW-1:0] r_acc;
  logic          r_cflag;

  div_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_wq;      // dividend shifting out / quotient shifting in
  logic [DW-1:0] r_wr;      // partial remainder
  logic [DW-1:0] r_dvs;
  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic          r_dbz;
  logic          r_busy;
  logic          r_done;

  logic [DW-1:0] w_alu;
  logic          w_alu_c;
  logic [DW-1:0] w_acc_src;
  logic [AW-1:0] w_ir_addr;
  logic [DW:0]   w_shift;
  logic          w_ge;
  logic [DW-1:0] w_sub;
  logic [DW-1:0] w_wr_next;
  logic [DW-1:0] w_wq_next;

  assign w_ir_addr = r_ir[DW-1:OW];

  always_comb begin
    w_alu   = '0;
    w_alu_c = 1'b0;
    case (bus.opALU)
      3'd0: {w_alu_c, w_alu} = {1'b0, r_acc} + {1'b0, r_mdr};
      3'd1: begin
        w_alu   = r_acc - r_mdr;
        w_alu_c = (r_acc < r_mdr);
      end
      3'd2: w_alu = r_acc & r_mdr;
      3'd3: w_alu = r_acc | r_mdr;
      3'd4: w_alu = r_acc ^ r_mdr;
      3'd5: w_alu = ~r_acc;
      3'd6: begin
        w_alu   = {r_acc[DW-2:0], 1'b0};
        w_alu_c = r_acc[DW-1];
      end
      3'd7: w_alu = r_mdr;
    endcase
  end

  always_comb begin
    w_acc_src = w_alu;
    case (bus.accSel)
      2'd0: w_acc_src = w_alu;
      2'd1: w_acc_src = r_mdr;
      2'd2: w_acc_src = r_quo;
      2'd3: w_acc_src = r_rem;
    endcase
  end

  // One restoring step. The shifted remainder needs DW+1 bits for the
  // compare; after a successful subtract it is below the divisor, so the
  // low DW bits of the difference are exact.
  always_comb begin
    w_shift   = {r_wr, r_wq[DW-1]};
    w_ge      = (w_shift >= {1'b0, r_dvs});
    w_sub     = w_shift[DW-1:0] - r_dvs;
    w_wr_next = w_ge ? w_sub : w_shift[DW-1:0];
    w_wq_next = {r_wq[DW-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= '0;
      r_mar   <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_acc   <= '0;
      r_cflag <= 1'b0;
    end else begin
      if (bus.loadPC)
        r_pc <= bus.muxPC ? w_ir_addr : r_pc + AW'(1);
      if (bus.loadMAR)
        r_mar <= bus.muxMAR ? w_ir_addr : r_pc;
      if (bus.loadIR)
        r_ir <= r_mdr;
      if (bus.loadMDR)
        r_mdr <= bus.MemQ;
      if (bus.loadACC) begin
        r_acc <= w_acc_src;
        if (bus.accSel == 2'd0)
          r_cflag <= w_alu_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wq    <= '0;
      r_wr    <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (bus.divStart) begin
            if (r_mdr == '0) begin
              // zero divisor: results are known immediately, skip RUN
              r_quo   <= '1;
              r_rem   <= r_acc;
              r_dbz   <= 1'b1;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_wq    <= r_acc;
              r_wr    <= '0;
              r_dvs   <= r_mdr;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_wq  <= w_wq_next;
          r_wr  <= w_wr_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW - 1)) begin
            r_quo   <= w_wq_next;
            r_rem   <= w_wr_next;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemAddr   = r_mar;
  assign bus.MemD      = r_acc;
  assign bus.opcode    = r_ir[OW-1:0];
  assign bus.ACC_reg   = r_acc;
  assign bus.MDR_reg   = r_mdr;
  assign bus.zflag     = (r_acc == '0);
  assign bus.cflag     = r_cflag;
  assign bus.divBusy   = r_busy;
  assign bus.divDone   = r_done;
  assign bus.divByZero = r_dbz;
endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: behavioural model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_param_datapath;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned OW = DW - AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_datapath_if #(.DW(DW), .AW(AW)) bus ();

  param_datapath #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [AW-1:0] m_pc, m_mar;
  logic [DW-1:0] m_ir, m_mdr, m_acc, m_quo, m_rem, m_pq, m_pr;
  logic          m_c, m_dbz, m_done;
  int            m_left;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [AW-1:0] n_pc, n_mar;
    logic [DW-1:0] n_ir, n_mdr, n_acc, n_quo, n_rem, n_pq, n_pr, res;
    logic          n_c, n_dbz, n_done, c;
    int            n_left;
    logic [DW:0]   sum;
    n_pc = m_pc; n_mar = m_mar; n_ir = m_ir; n_mdr = m_mdr; n_acc = m_acc;
    n_quo = m_quo; n_rem = m_rem; n_pq = m_pq; n_pr = m_pr;
    n_c = m_c; n_dbz = m_dbz; n_done = 1'b0; n_left = m_left;
    if (!rst) begin
      n_pc = '0; n_mar = '0; n_ir = '0; n_mdr = '0; n_acc = '0;
      n_quo = '0; n_rem = '0; n_c = 1'b0; n_dbz = 1'b0; n_left = 0;
    end else begin
      if (bus.loadPC)  n_pc  = bus.muxPC  ? m_ir[DW-1:OW] : m_pc + AW'(1);
      if (bus.loadMAR) n_mar = bus.muxMAR ? m_ir[DW-1:OW] : m_pc;
      if (bus.loadIR)  n_ir  = m_mdr;
      if (bus.loadMDR) n_mdr = bus.MemQ;
      c = 1'b0;
      case (bus.opALU)
        3'd0: begin sum = m_acc + m_mdr; res = sum[DW-1:0]; c = sum[DW]; end
        3'd1: begin res = m_acc - m_mdr; c = (m_acc < m_mdr); end
        3'd2: res = m_acc & m_mdr;
        3'd3: res = m_acc | m_mdr;
        3'd4: res = m_acc ^ m_mdr;
        3'd5: res = ~m_acc;
        3'd6: begin res = m_acc << 1; c = m_acc[DW-1]; end
        default: res = m_mdr;
      endcase
      if (bus.loadACC) begin
        case (bus.accSel)
          2'd0: begin n_acc = res; n_c = c; end
          2'd1: n_acc = m_mdr;
          2'd2: n_acc = m_quo;
          default: n_acc = m_rem;
        endcase
      end
      if (m_left > 0) begin
        n_left = m_left - 1;
        if (n_left == 0) begin n_quo = m_pq; n_rem = m_pr; n_done = 1'b1; end
      end else if (bus.divStart) begin
        if (m_mdr == '0) begin
          n_quo = '1; n_rem = m_acc; n_dbz = 1'b1; n_done = 1'b1;
        end else begin
          n_pq = m_acc / m_mdr; n_pr = m_acc % m_mdr;
          n_left = DW; n_dbz = 1'b0;
        end
      end
    end
    m_pc = n_pc; m_mar = n_mar; m_ir = n_ir; m_mdr = n_mdr; m_acc = n_acc;
    m_quo = n_quo; m_rem = n_rem; m_pq = n_pq; m_pr = n_pr;
    m_c = n_c; m_dbz = n_dbz; m_done = n_done; m_left = n_left;
  endtask

  task automatic compare_all();
    chk("MemAddr",   bus.MemAddr,   m_mar);
    chk("MemD",      bus.MemD,      m_acc);
    chk("opcode",    bus.opcode,    m_ir[OW-1:0]);
    chk("ACC_reg",   bus.ACC_reg,   m_acc);
    chk("MDR_reg",   bus.MDR_reg,   m_mdr);
    chk("zflag",     bus.zflag,     m_acc == '0);
    chk("cflag",     bus.cflag,     m_c);
    chk("divBusy",   bus.divBusy,   m_left > 0);
    chk("divDone",   bus.divDone,   m_done);
    chk("divByZero", bus.divByZero, m_dbz);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clr();
    rst = 1'b1;
    bus.loadPC = 1'b0; bus.muxPC = 1'b0; bus.loadMAR = 1'b0; bus.muxMAR = 1'b0;
    bus.loadIR = 1'b0; bus.loadMDR = 1'b0; bus.loadACC = 1'b0;
    bus.accSel = 2'd0; bus.opALU = 3'd0; bus.divStart = 1'b0; bus.MemQ = '0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    clr(); bus.MemQ = v; bus.loadMDR = 1'b1; cycle(); clr();
  endtask

  task automatic acc_from(input logic [1:0] sel);
    clr(); bus.loadACC = 1'b1; bus.accSel = sel; cycle(); clr();
  endtask

  task automatic set_acc(input logic [DW-1:0] v);
    load_mdr(v); acc_from(2'd1);
  endtask

  task automatic alu(input logic [2:0] op);
    clr(); bus.loadACC = 1'b1; bus.accSel = 2'd0; bus.opALU = op; cycle(); clr();
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    load_mdr({v, {OW{1'b0}}});
    clr(); bus.loadIR = 1'b1; cycle();
    clr(); bus.loadPC = 1'b1; bus.muxPC = 1'b1; cycle(); clr();
  endtask

  task automatic pc_to_mar();
    clr(); bus.loadMAR = 1'b1; bus.muxMAR = 1'b0; cycle(); clr();
  endtask

  task automatic div_start();
    clr(); bus.divStart = 1'b1; cycle(); clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, nd;
    m_left = 0;
    clr();
    rst = 1'b0;
    cycle();
    cycle();
    clr();
    chk("rst_zflag",   bus.zflag,   1'b1);
    chk("rst_MemAddr", bus.MemAddr, '0);
    chk("rst_MemD",    bus.MemD,    '0);
    chk("rst_opcode",  bus.opcode,  '0);
    chk("rst_cflag",   bus.cflag,   1'b0);
    chk("rst_busy",    bus.divBusy, 1'b0);

    // fetch
    set_pc(8'h05);
    pc_to_mar();
    chk("fetch_mar", bus.MemAddr, 8'h05);
    load_mdr(16'h2A03);
    chk("fetch_mdr", bus.MDR_reg, 16'h2A03);
    clr(); bus.loadIR = 1'b1; cycle(); clr();
    chk("fetch_opcode", bus.opcode, 8'h03);
    clr(); bus.loadPC = 1'b1; bus.muxPC = 1'b1; cycle(); clr();
    pc_to_mar();
    chk("fetch_pc", bus.MemAddr, 8'h2A);

    // loadIR with loadMDR in the same cycle takes the old MDR
    clr(); bus.loadIR = 1'b1; bus.loadMDR = 1'b1; bus.MemQ = 16'h5566; cycle(); clr();
    chk("ir_old_mdr", bus.opcode, 8'h03);

    // PC wrap
    set_pc(8'hFF);
    clr(); bus.loadPC = 1'b1; cycle(); clr();
    pc_to_mar();
    chk("pc_wrap", bus.MemAddr, 8'h00);

    // ALU flags
    set_acc(16'hFFFF);
    load_mdr(16'h0001);
    alu(3'd0);
    chk("add_acc", bus.ACC_reg, 16'h0000);
    chk("add_c",   bus.cflag,   1'b1);
    chk("add_z",   bus.zflag,   1'b1);
    alu(3'd1);
    chk("sub_acc", bus.ACC_reg, 16'hFFFF);
    chk("sub_c",   bus.cflag,   1'b1);
    alu(3'd6);
    chk("shl_acc", bus.ACC_reg, 16'hFFFE);
    chk("shl_c",   bus.cflag,   1'b1);

    // divide 100 / 7
    set_acc(16'd100);
    load_mdr(16'd7);
    div_start();
    nb = 0;
    for (int i = 0; i < 40 && !bus.divDone; i++) begin
      if (bus.divBusy) nb++;
      cycle();
    end
    chk("div_done",  bus.divDone, 1'b1);
    chk("div_busyn", 16'(nb),     16'd16);
    acc_from(2'd2);
    chk("div_quo", bus.ACC_reg, 16'd14);
    acc_from(2'd3);
    chk("div_rem", bus.ACC_reg, 16'd2);
    chk("div_dbz", bus.divByZero, 1'b0);

    // divide by zero
    set_acc(16'h1234);
    load_mdr(16'h0000);
    div_start();
    chk("dbz_done", bus.divDone,   1'b1);
    chk("dbz_flag", bus.divByZero, 1'b1);
    acc_from(2'd2);
    chk("dbz_quo", bus.ACC_reg, 16'hFFFF);
    acc_from(2'd3);
    chk("dbz_rem", bus.ACC_reg, 16'h1234);

    // abort by reset at RUN cycle 8
    set_acc(16'd100);
    load_mdr(16'd7);
    div_start();
    for (int i = 0; i < 7; i++) cycle();
    clr(); rst = 1'b0; cycle(); clr();
    chk("abort_busy", bus.divBusy, 1'b0);
    nd = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (bus.divDone) nd++;
    end
    chk("abort_nodone", 16'(nd), 16'd0);
    acc_from(2'd2);
    chk("abort_quo", bus.ACC_reg, 16'd0);

    // second divStart during RUN is ignored
    set_acc(16'd50);
    load_mdr(16'd5);
    div_start();
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) bus.divStart = 1'b1;
      cycle();
      clr();
      if (bus.divDone) nd++;
    end
    chk("restart_once", 16'(nd), 16'd1);
    acc_from(2'd2);
    chk("restart_quo", bus.ACC_reg, 16'd10);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) != 0);
      bus.loadPC   = 1'($urandom_range(0, 1));
      bus.muxPC    = 1'($urandom_range(0, 1));
      bus.loadMAR  = 1'($urandom_range(0, 1));
      bus.muxMAR   = 1'($urandom_range(0, 1));
      bus.loadIR   = 1'($urandom_range(0, 1));
      bus.loadMDR  = 1'($urandom_range(0, 1));
      bus.loadACC  = 1'($urandom_range(0, 1));
      bus.accSel   = 2'($urandom_range(0, 3));
      bus.opALU    = 3'($urandom_range(0, 7));
      bus.divStart = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       bus.MemQ = '0;
        1:       bus.MemQ = DW'($urandom_range(1, 40));
        default: bus.MemQ = DW'($urandom);
      endcase
      cycle();
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
